// File: rtl/seg_frame_decoder.sv
// rtl/seg_frame_decoder.sv - scanned 7-segment bus to hex frame decoder
//
// Samples a multiplexed 7-segment bus, waits for each glyph to settle,
// decodes it to a hex nibble and assembles one nibble per digit into a
// frame that is handed out on a valid/ready interface.
//
// Ports:
//   clk          single clock
//   rst_n        synchronous active-low reset
//   seg[6:0]     segment lines, bit6=a ... bit0=g
//   dig[D-1:0]   digit strobes, one-hot when valid
//   frame_data   decoded nibbles, digit i at [4i+3:4i]
//   frame_err    bit i set when digit i held an undecodable glyph
//   frame_valid  frame available
//   frame_ready  consumer accepts frame
//   overrun      sticky, a completed frame was dropped

module seg_frame_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
);

  localparam int         SW      = 7 + DIGITS;
  // Capture is decided on the sample that moves the counter to STABLE_CYCLES-1.
  localparam logic [7:0] CAP_AT  = 8'(STABLE_CYCLES - 2);
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  typedef enum logic {S_EMPTY, S_FULL} out_state_e;

  logic [6:0]          seg_s1_q, seg_s2_q;
  logic [DIGITS-1:0]   dig_s1_q, dig_s2_q;
  logic [SW-1:0]       prev_q;
  logic [7:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] slot_nib_q, slot_nib_d;
  logic [DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  out_state_e          state_q, state_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                overrun_q, overrun_d;

  logic [6:0]          seg_s;
  logic [DIGITS-1:0]   dig_s;
  logic [SW-1:0]       cur;
  logic                same;
  logic                one_hot;
  logic                capture;
  logic                complete;
  logic                load;
  logic [4:0]          dec;

  // Returns {err, nibble}; unknown patterns map to nibble 0 with err set.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      7'b1110111: r = 5'h0A;
      7'b0011111: r = 5'h0B;
      7'b1001110: r = 5'h0C;
      7'b0111101: r = 5'h0D;
      7'b1001111: r = 5'h0E;
      7'b1000111: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    seg_s   = seg_s2_q ^ {7{ACTIVE_LOW}};
    dig_s   = dig_s2_q ^ {DIGITS{ACTIVE_LOW}};
    cur     = {seg_s, dig_s};
    same    = (cur == prev_q);
    one_hot = (dig_s != '0) && ((dig_s & (dig_s - DIGITS'(1))) == '0);
    capture = same && one_hot && (cnt_q == CAP_AT);
    dec     = decode_glyph(seg_s);

    // A bad strobe pins the counter at 0 so it must restart once it clears.
    cnt_d = cnt_q;
    if (!same || !one_hot) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end

    slot_nib_d = slot_nib_q;
    slot_err_d = slot_err_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (capture && dig_s[i]) begin
        slot_nib_d[4*i +: 4] = dec[3:0];
        slot_err_d[i]        = dec[4];
      end
    end

    complete = &mask_q;
    mask_d   = (complete ? '0 : mask_q) | (capture ? dig_s : '0);
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      S_EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (complete) begin
          // Accept in the completion cycle frees the register for the new frame.
          if (frame_ready) begin
            load = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (frame_ready) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    data_d = load ? slot_nib_q : data_q;
    err_d  = load ? slot_err_q : err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      dig_s1_q   <= '0;
      dig_s2_q   <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      slot_nib_q <= '0;
      slot_err_q <= '0;
      mask_q     <= '0;
      state_q    <= S_EMPTY;
      data_q     <= '0;
      err_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      seg_s1_q   <= seg;
      seg_s2_q   <= seg_s1_q;
      dig_s1_q   <= dig;
      dig_s2_q   <= dig_s1_q;
      prev_q     <= cur;
      cnt_q      <= cnt_d;
      slot_nib_q <= slot_nib_d;
      slot_err_q <= slot_err_d;
      mask_q     <= mask_d;
      state_q    <= state_d;
      data_q     <= data_d;
      err_q      <= err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_err   = err_q;
  assign frame_valid = (state_q == S_FULL);
  assign overrun     = overrun_q;

endmodule
